// File: rtl/jeff_counter_nbit.sv
// jeff_counter_nbit: presettable N-bit up/down counter with a programmable
// modulus, wrap or saturate at the terminal value, cascade enables
// (ent/enp with rco) and a sticky overflow/underflow flag.
module jeff_counter_nbit #(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 2**WIDTH-1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] step_v;
  logic [WIDTH-1:0] wrap_v;
  logic [WIDTH-1:0] d_clamped;
  logic             at_term;

  // Load data is clamped to MAX_COUNT; with a full binary modulus every d
  // is already legal, so no comparator is built.
  generate
    if (MAX_COUNT >= (2**WIDTH) - 1) begin : g_full_range
      assign d_clamped = d;
    end else begin : g_clamp
      assign d_clamped = (d > MAX_V) ? MAX_V : d;
    end
  endgenerate

  // Direction-dependent terminal value, the plain +/-1 step and the value
  // taken when wrapping past the terminal.
  always_comb begin
    term    = up ? MAX_V : ZERO_V;
    at_term = (q_q == term);
    step_v  = up ? (q_q + ONE_V) : (q_q - ONE_V);
    wrap_v  = up ? ZERO_V : MAX_V;
  end

  // Next-state: load beats counting; counting stops at the terminal value,
  // so q can never step beyond MAX_COUNT even for non-binary moduli.
  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (ld) begin
      q_d   = d_clamped;
      ovf_d = 1'b0;
    end else if (ent && enp) begin
      if (at_term) begin
        ovf_d = 1'b1;
        if (!sat) begin
          q_d = wrap_v;
        end
      end else begin
        q_d = step_v;
      end
    end
  end

  // State registers; clr has the highest priority of all operations.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q   <= RST_V;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  // Carry out is purely combinational so a chained stage sees it in the
  // same cycle; it ignores enp so the whole chain shares one enp.
  assign rco = ent & at_term;

endmodule

// File: tb/tb_jeff_counter_nbit.sv
// Testbench for jeff_counter_nbit: a decade instance checked against a
// modular-arithmetic model, a two-stage decade cascade and a full 8-bit
// binary instance.
module tb_jeff_counter_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Decade instance (WIDTH=4, MAX_COUNT=9)
  logic       clr, ld, ent, enp, up, sat;
  logic [3:0] d;
  logic [3:0] q;
  logic       rco, ovf;

  jeff_counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0)) dut (
    .clk(clk), .clr(clr), .ld(ld), .ent(ent), .enp(enp), .up(up),
    .sat(sat), .d(d), .q(q), .rco(rco), .ovf(ovf)
  );

  // Two-stage decade cascade
  logic       c_clr, c_ld, c_ent_lo, c_enp, c_up, c_sat;
  logic [3:0] c_d;
  logic [3:0] c_q_lo, c_q_hi;
  logic       c_rco_lo, c_rco_hi, c_ovf_lo, c_ovf_hi;

  jeff_counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0)) u_lo (
    .clk(clk), .clr(c_clr), .ld(c_ld), .ent(c_ent_lo), .enp(c_enp),
    .up(c_up), .sat(c_sat), .d(c_d), .q(c_q_lo), .rco(c_rco_lo), .ovf(c_ovf_lo)
  );

  jeff_counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0)) u_hi (
    .clk(clk), .clr(c_clr), .ld(c_ld), .ent(c_rco_lo), .enp(c_enp),
    .up(c_up), .sat(c_sat), .d(c_d), .q(c_q_hi), .rco(c_rco_hi), .ovf(c_ovf_hi)
  );

  // Full-width binary instance (WIDTH=8, default MAX_COUNT)
  logic       w_clr, w_ld, w_ent, w_enp, w_up, w_sat;
  logic [7:0] w_d;
  logic [7:0] w_q;
  logic       w_rco, w_ovf;

  jeff_counter_nbit #(.WIDTH(8)) u_w8 (
    .clk(clk), .clr(w_clr), .ld(w_ld), .ent(w_ent), .enp(w_enp), .up(w_up),
    .sat(w_sat), .d(w_d), .q(w_q), .rco(w_rco), .ovf(w_ovf)
  );

  // Reference model of the decade instance: count value as an integer in
  // 0..9, moving by modular arithmetic on the modulus 10.
  int m_q;
  bit m_ovf;

  task automatic model_step();
    int nxt;
    bit hit;
    if (clr) begin
      m_q   = 0;
      m_ovf = 0;
    end else if (ld) begin
      m_q   = (int'(d) > 9) ? 9 : int'(d);
      m_ovf = 0;
    end else if (ent && enp) begin
      nxt = up ? (m_q + 1) % 10 : (m_q + 9) % 10;
      hit = up ? (nxt == 0) : (nxt == 9);
      if (hit) begin
        m_ovf = 1;
        if (sat) nxt = m_q;
      end
      m_q = nxt;
    end
  endtask

  function automatic bit m_rco();
    return ent && (m_q == (up ? 9 : 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_main(input string tag);
    model_step();
    tick();
    $display("[%0t] %s clr=%0b ld=%0b ent=%0b enp=%0b up=%0b sat=%0b d=%0d -> q=%0d ovf=%0b rco=%0b",
             $time, tag, clr, ld, ent, enp, up, sat, d, q, ovf, rco);
  endtask

  task automatic test_reset();
    clr = 1; ld = 0; ent = 0; enp = 0; up = 1; sat = 0; d = 4'd7;
    step_main("reset");
    clr = 0;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    ent = 1; up = 0; #1;
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL reset_rco_down got %0b want 1", rco); end
    up = 1; #1;
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL reset_rco_up got %0b want 0", rco); end
  endtask

  task automatic test_up_wrap();
    int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    ent = 1; enp = 1; up = 1; sat = 0;
    for (int i = 0; i < 12; i++) begin
      step_main("up_wrap");
      checks++; if (q !== 4'(exp_q[i])) begin errors++; $display("FAIL up_wrap_q[%0d] got %0d want %0d", i, q, exp_q[i]); end
      checks++; if (ovf !== (i >= 9)) begin errors++; $display("FAIL up_wrap_ovf[%0d] got %0b want %0b", i, ovf, i >= 9); end
      checks++; if (rco !== (exp_q[i] == 9)) begin errors++; $display("FAIL up_wrap_rco[%0d] got %0b want %0b", i, rco, exp_q[i] == 9); end
    end
  endtask

  task automatic test_down_sat();
    int exp_q[5]   = '{1, 0, 0, 0, 0};
    bit exp_ovf[5] = '{0, 0, 1, 1, 1};
    ld = 1; d = 4'd2; ent = 0; enp = 0;
    step_main("down_sat_load");
    ld = 0;
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL down_sat_load_q got %0d want 2", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL down_sat_load_ovf got %0b want 0", ovf); end
    up = 0; sat = 1; ent = 1; enp = 1;
    for (int i = 0; i < 5; i++) begin
      step_main("down_sat");
      checks++; if (q !== 4'(exp_q[i])) begin errors++; $display("FAIL down_sat_q[%0d] got %0d want %0d", i, q, exp_q[i]); end
      checks++; if (ovf !== exp_ovf[i]) begin errors++; $display("FAIL down_sat_ovf[%0d] got %0b want %0b", i, ovf, exp_ovf[i]); end
      checks++; if (rco !== (exp_q[i] == 0)) begin errors++; $display("FAIL down_sat_rco[%0d] got %0b want %0b", i, rco, exp_q[i] == 0); end
    end
  endtask

  task automatic test_enable_gating();
    ld = 1; d = 4'd9; up = 1; sat = 0; ent = 0; enp = 0;
    step_main("gate_load");
    ld = 0; ent = 1; enp = 0;
    step_main("gate_ent_only");
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL gate_hold_q got %0d want 9", q); end
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL gate_rco_ent got %0b want 1", rco); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL gate_ovf got %0b want 0", ovf); end
    ent = 0; #1;
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL gate_rco_noent got %0b want 0", rco); end
    step_main("gate_ent_off");
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL gate_hold2_q got %0d want 9", q); end
    ent = 1; up = 1; #1;
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL gate_rco_up got %0b want 1", rco); end
    up = 0; #1;
    checks++; if (rco !== 1'b0) begin errors++; $display("FAIL gate_rco_toggle got %0b want 0", rco); end
    up = 1; ent = 0;
  endtask

  task automatic test_priority_clamp();
    // Saturate at 9 to get ovf set, then clamp-load clears it.
    ent = 1; enp = 1; up = 1; sat = 1;
    step_main("prio_sat");
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL prio_sat_q got %0d want 9", q); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL prio_sat_ovf got %0b want 1", ovf); end
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL prio_sat_rco got %0b want 1", rco); end
    ld = 1; d = 4'hF; ent = 0;
    step_main("prio_clamp");
    ld = 0; ent = 1;
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL prio_clamp_q got %0d want 9", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL prio_clamp_ovf got %0b want 0", ovf); end
    #1;
    checks++; if (rco !== 1'b1) begin errors++; $display("FAIL prio_clamp_rco got %0b want 1", rco); end
    clr = 1; ld = 1; d = 4'd5;
    step_main("prio_clr_ld");
    clr = 0;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL prio_clr_ld_q got %0d want 0", q); end
    ld = 1; d = 4'd9; ent = 0;
    step_main("prio_load9");
    ld = 0; ent = 1; enp = 1; sat = 1;
    step_main("prio_hit");
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL prio_hit_ovf got %0b want 1", ovf); end
    ld = 1; d = 4'd3;
    step_main("prio_ld_term");
    ld = 0;
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL prio_ld_term_q got %0d want 3", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL prio_ld_term_ovf got %0b want 0", ovf); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      clr = ($urandom_range(0, 31) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      ent = ($urandom_range(0, 5) != 0);
      enp = ($urandom_range(0, 5) != 0);
      up  = ($urandom_range(0, 3) != 0) ? up : ~up;
      sat = $urandom_range(0, 1);
      d   = 4'($urandom_range(0, 15));
      #1;
      checks++; if (rco !== m_rco()) begin errors++; $display("FAIL rand_rco[%0d] got %0b want %0b", i, rco, m_rco()); end
      step_main("random");
      checks++; if (q !== 4'(m_q)) begin errors++; $display("FAIL rand_q[%0d] got %0d want %0d", i, q, m_q); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf[%0d] got %0b want %0b", i, ovf, m_ovf); end
    end
    clr = 0; ld = 0; ent = 0; enp = 0;
  endtask

  task automatic test_cascade();
    c_clr = 1; c_ld = 0; c_ent_lo = 0; c_enp = 0; c_up = 1; c_sat = 0; c_d = 4'd0;
    tick();
    c_clr = 0;
    checks++; if ({c_q_hi, c_q_lo} !== 8'h00) begin errors++; $display("FAIL casc_reset got %0d%0d want 00", c_q_hi, c_q_lo); end
    c_ent_lo = 1; c_enp = 1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      $display("[%0t] cascade n=%0d -> hi=%0d lo=%0d ovf_hi=%0b", $time, n, c_q_hi, c_q_lo, c_ovf_hi);
      checks++; if (c_q_lo !== 4'(n % 10)) begin errors++; $display("FAIL casc_lo[%0d] got %0d want %0d", n, c_q_lo, n % 10); end
      checks++; if (c_q_hi !== 4'((n / 10) % 10)) begin errors++; $display("FAIL casc_hi[%0d] got %0d want %0d", n, c_q_hi, (n / 10) % 10); end
      checks++; if (c_ovf_hi !== (n >= 100)) begin errors++; $display("FAIL casc_ovf_hi[%0d] got %0b want %0b", n, c_ovf_hi, n >= 100); end
      checks++; if (c_ovf_lo !== (n >= 10)) begin errors++; $display("FAIL casc_ovf_lo[%0d] got %0b want %0b", n, c_ovf_lo, n >= 10); end
    end
    c_ent_lo = 0; c_enp = 0;
  endtask

  task automatic test_full_width();
    w_clr = 1; w_ld = 0; w_ent = 0; w_enp = 0; w_up = 1; w_sat = 0; w_d = 8'd0;
    tick();
    w_clr = 0;
    checks++; if (w_q !== 8'd0) begin errors++; $display("FAIL w8_reset got %0d want 0", w_q); end
    w_ent = 1; w_enp = 1;
    for (int n = 1; n <= 256; n++) begin
      tick();
      $display("[%0t] w8_up n=%0d -> q=%0d ovf=%0b rco=%0b", $time, n, w_q, w_ovf, w_rco);
      checks++; if (w_q !== 8'(n % 256)) begin errors++; $display("FAIL w8_q[%0d] got %0d want %0d", n, w_q, n % 256); end
      checks++; if (w_ovf !== (n >= 256)) begin errors++; $display("FAIL w8_ovf[%0d] got %0b want %0b", n, w_ovf, n >= 256); end
      checks++; if (w_rco !== ((n % 256) == 255)) begin errors++; $display("FAIL w8_rco[%0d] got %0b want %0b", n, w_rco, (n % 256) == 255); end
    end
    w_up = 0;
    tick();
    $display("[%0t] w8_down -> q=%0d ovf=%0b", $time, w_q, w_ovf);
    checks++; if (w_q !== 8'hFF) begin errors++; $display("FAIL w8_down_q got %0d want 255", w_q); end
    checks++; if (w_ovf !== 1'b1) begin errors++; $display("FAIL w8_down_ovf got %0b want 1", w_ovf); end
    w_ent = 0; w_enp = 0;
  endtask

  initial begin
    clr = 1; ld = 0; ent = 0; enp = 0; up = 1; sat = 0; d = '0;
    c_clr = 1; c_ld = 0; c_ent_lo = 0; c_enp = 0; c_up = 1; c_sat = 0; c_d = '0;
    w_clr = 1; w_ld = 0; w_ent = 0; w_enp = 0; w_up = 1; w_sat = 0; w_d = '0;
    m_q = 0; m_ovf = 0;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_enable_gating();
    test_priority_clamp();
    test_random();
    test_cascade();
    test_full_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
